sipo_5bit_rx: RTL and testbench

Serial-in, parallel-out receiver for the 5-bit serial stream produced by the team's parallel-in serial-out shifter, which sends the MSB first. It samples one bit per qualified clock, frames words on an explicit start marker, and presents each completed 5-bit word in a holding register with a valid/ready handshake. It also reports overrun and, optionally, parity errors. It sits at the receive end of the same link, directly feeding downstream parallel logic.

---
 rtl/sipo_5bit_rx.sv | 208 ++++++++++++++++++++
 tb/tb_sipo_5bit_rx.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sipo_5bit_rx.sv
// ---------------------------------------------------------------------------
// sipo_5bit_rx
//
// Serial-in, parallel-out receiver for the MSB-first 5-bit stream produced by
// the companion parallel-in serial-out shifter. One bit is taken on every
// clock where sin_en is high. A word is framed by 'start', which marks the
// current bit as the MSB. Each completed word is moved into a holding register
// that the consumer drains through a valid/ready handshake.
//
// Optional feature macro: SIPO_PARITY_EN
//   When it is defined, an even-parity bit follows the LSB of every word. A
//   mismatch still delivers the word, but it sets the sticky parity_err flag.
//   When it is undefined, the PAR state, the parity logic and the parity_err
//   port are all absent.
//
// Ports
//   clk         in   rising-edge clock, sole clock domain
//   rst_n       in   synchronous active-low reset
//   sin         in   serial data bit, MSB first
//   sin_en      in   bit qualifier; sin and start are only looked at when 1
//   start       in   current bit is the MSB of a new word
//   data_out    out  [WIDTH] holding register, MSB = first bit received
//   data_valid  out  holding register contains an unconsumed word
//   data_ready  in   consumer accepts data_out this cycle
//   busy        out  word reception in progress (state != IDLE)
//   overrun     out  sticky: a completed word was dropped (holding reg full)
//   parity_err  out  sticky parity mismatch (SIPO_PARITY_EN builds only)
//   state_dbg   out  [2] current FSM state, for checkers
//
// Handshake: data_out is transferred when data_valid=1 and data_ready=1 on the
// same rising edge. While data_valid=1 and no transfer occurs, data_out is
// held stable. data_valid is never withdrawn without a transfer, except by
// reset.
// ---------------------------------------------------------------------------
module sipo_5bit_rx #(
    parameter int WIDTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             start,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic             overrun,
`ifdef SIPO_PARITY_EN
    output logic             parity_err,
`endif
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

`ifdef SIPO_PARITY_EN
    // The full word has to wait in the shift register while the parity bit
    // arrives, so the register keeps all WIDTH bits.
    localparam int SW = WIDTH;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1,
        PAR  = 2'd2
    } state_t;
`else
    // Without parity, a word completes on the same edge that samples its
    // last bit. Only the first WIDTH-1 bits ever have to be stored.
    localparam int SW = WIDTH - 1;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RECV = 2'd1
    } state_t;
`endif

    state_t          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [SW-1:0]   shift_q, shift_d;
    logic [WIDTH-1:0] shifted_word;
    logic [WIDTH-1:0] word;
    logic            complete;
`ifdef SIPO_PARITY_EN
    logic            par_bad;
`endif

    // The partial word with the current serial bit appended at the LSB.
`ifdef SIPO_PARITY_EN
    assign shifted_word = {shift_q[WIDTH-2:0], sin};
`else
    assign shifted_word = {shift_q, sin};
`endif

    // -----------------------------------------------------------------------
    // FSM state register and shift/count datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            shift_q <= shift_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. A start bit wins over everything else. An abort of a
    // partial word is therefore silent, even when the aborting bit would
    // otherwise have been the final bit of the old word.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        shift_d  = shift_q;
        word     = shifted_word;
        complete = 1'b0;
`ifdef SIPO_PARITY_EN
        par_bad  = 1'b0;
`endif
        if (sin_en) begin
            if (start) begin
                state_d    = RECV;
                count_d    = CW'(1);
                shift_d    = '0;
                shift_d[0] = sin;
            end else begin
                case (state_q)
                    IDLE: begin
                        // Bits outside a framed word are ignored.
                    end
                    RECV: begin
                        shift_d = shifted_word[SW-1:0];
                        if (count_q == LAST_CNT) begin
`ifdef SIPO_PARITY_EN
                            state_d = PAR;
                            count_d = count_q + CW'(1);
`else
                            state_d  = IDLE;
                            count_d  = '0;
                            word     = shifted_word;
                            complete = 1'b1;
`endif
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end
`ifdef SIPO_PARITY_EN
                    PAR: begin
                        // The parity bit is not shifted in. The word is
                        // already complete in the shift register.
                        state_d  = IDLE;
                        count_d  = '0;
                        word     = shift_q;
                        complete = 1'b1;
                        par_bad  = (sin != (^shift_q));
                    end
`endif
                    default: begin
                        state_d = IDLE;
                        count_d = '0;
                    end
                endcase
            end
        end
    end

    // -----------------------------------------------------------------------
    // Holding register and sticky flags. A completion that coincides with an
    // acceptance replaces the word in place. data_valid stays high and the
    // overrun flag is not raised.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (complete) begin
                if (!data_valid || data_ready) begin
                    data_out   <= word;
                    data_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end
        end
    end

`ifdef SIPO_PARITY_EN
    // A parity mismatch is recorded even if the word itself is then dropped
    // because of an overrun.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity_err <= 1'b0;
        end else if (complete && par_bad) begin
            parity_err <= 1'b1;
        end
    end
`endif

    assign busy      = (state_q != IDLE);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_sipo_5bit_rx.sv
module tb_sipo_5bit_rx;

  localparam int W = 5;
`ifdef SIPO_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic         sin = 1'b0;
  logic         sin_en = 1'b0;
  logic         start = 1'b0;
  logic         data_ready = 1'b0;
  logic [W-1:0] data_out;
  logic         data_valid;
  logic         busy;
  logic         overrun;
  logic [1:0]   state_dbg;
`ifdef SIPO_PARITY_EN
  logic         parity_err;
`endif

  sipo_5bit_rx #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sin        (sin),
    .sin_en     (sin_en),
    .start      (start),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .busy       (busy),
    .overrun    (overrun),
`ifdef SIPO_PARITY_EN
    .parity_err (parity_err),
`endif
    .state_dbg  (state_dbg)
  );

  // ---------------- scoreboard / reference model ----------------
  int n_pass = 0;
  int n_total = 0;
  int n_fail = 0;

  logic [W-1:0] exp_q[$];   // words delivered but not yet consumed

  int           m_nb;       // bits of the current word seen so far (0 = idle)
  int           m_acc;      // value of the data bits seen so far
  logic [W-1:0] m_data;
  logic         m_valid;
  logic         m_ovr;
  logic         m_perr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_nb = 0;
    m_acc = 0;
    m_data = '0;
    m_valid = 1'b0;
    m_ovr = 1'b0;
    m_perr = 1'b0;
    exp_q.delete();
  endtask

  // Reference behaviour: accumulate the word arithmetically (acc = 2*acc + bit).
  // A word is done after W data bits, or after W data bits plus a parity bit.
  task automatic model_step(input logic en, input logic st, input logic b, input logic rdy);
    bit done;
    bit bad;
    logic [W-1:0] w;
    done = 1'b0;
    bad = 1'b0;
    w = '0;
    if (en) begin
      if (st) begin
        m_acc = int'(b);
        m_nb = 1;
      end else if (m_nb > 0) begin
        if (m_nb < W) begin
          m_acc = m_acc * 2 + int'(b);
          m_nb++;
          if (m_nb == W && !HAS_PAR) begin
            done = 1'b1;
            w = W'(m_acc);
            m_nb = 0;
          end
        end else begin
          done = 1'b1;
          w = W'(m_acc);
          bad = (($countones(w) % 2) != int'(b));
          m_nb = 0;
        end
      end
    end
    if (done) begin
      if (bad) m_perr = 1'b1;
      if (!m_valid || rdy) begin
        m_data = w;
        m_valid = 1'b1;
        exp_q.push_back(w);
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  // ---------------- driver ----------------
  // Inputs are driven just after a rising edge, and outputs are checked 1ns
  // after the next rising edge.
  task automatic tick(input logic en, input logic st, input logic b, input logic rdy);
    sin_en = en;
    start = st;
    sin = b;
    data_ready = rdy;
    #1;
    if (rst_n && m_valid && rdy && exp_q.size() > 0)
      check("accepted_word", 32'(data_out), 32'(exp_q.pop_front()));
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_step(en, st, b, rdy);
    #1;
    check("data_out", 32'(data_out), 32'(m_data));
    check("data_valid", 32'(data_valid), 32'(m_valid));
    check("busy", 32'(busy), 32'(m_nb > 0));
    check("overrun", 32'(overrun), 32'(m_ovr));
`ifdef SIPO_PARITY_EN
    check("parity_err", 32'(parity_err), 32'(m_perr));
`endif
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  // Send a whole word MSB first. gap = idle (sin_en=0) cycles between bits.
  // rdy_last is applied on the completion cycle.
  task automatic send_word(input logic [W-1:0] v, input int gap, input logic rdy_body,
                           input logic rdy_last, input logic bad_par);
    for (int i = W - 1; i >= 0; i--) begin
      logic fin;
      fin = (i == 0) && !HAS_PAR;
      tick(1'b1, logic'(i == W - 1), v[i], fin ? rdy_last : rdy_body);
      if (!fin)
        for (int g = 0; g < gap; g++) tick(1'b0, 1'b0, 1'b0, rdy_body);
    end
    if (HAS_PAR) tick(1'b1, 1'b0, (^v) ^ bad_par, rdy_last);
  endtask

  // ---------------- directed steps, then random traffic ----------------
  initial begin
    model_reset();
    do_reset();
    check("reset_data_out", 32'(data_out), 32'h0);
    check("reset_valid", 32'(data_valid), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);

    // 1,0,1,1,0 continuous
    send_word(5'h16, 0, 1'b0, 1'b0, 1'b0);
    check("t1_data", 32'(data_out), 32'h16);
    check("t1_valid", 32'(data_valid), 32'h1);
    check("t1_busy", 32'(busy), 32'h0);

    // consume, then 5'h13 with one-cycle gaps between bits
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check("t2_drained", 32'(data_valid), 32'h0);
    send_word(5'h13, 1, 1'b0, 1'b0, 1'b0);
    check("t2_data", 32'(data_out), 32'h13);
    check("t2_valid", 32'(data_valid), 32'h1);

    // overrun: hold ready low across two words
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    send_word(5'h0A, 0, 1'b0, 1'b0, 1'b0);
    send_word(5'h15, 0, 1'b0, 1'b0, 1'b0);
    check("t3_data", 32'(data_out), 32'h0A);
    check("t3_overrun", 32'(overrun), 32'h1);
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    check("t3_valid_after_accept", 32'(data_valid), 32'h0);
    check("t3_overrun_sticky", 32'(overrun), 32'h1);

    // back-to-back, accept coincides with completion of the second word
    do_reset();
    send_word(5'h1F, 0, 1'b0, 1'b0, 1'b0);
    send_word(5'h01, 0, 1'b0, 1'b1, 1'b0);
    check("t4_data", 32'(data_out), 32'h01);
    check("t4_valid", 32'(data_valid), 32'h1);
    check("t4_overrun", 32'(overrun), 32'h0);

    // abort: 1,1,0 then restart with 0,0,1,1,1
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    send_word(5'h07, 0, 1'b0, 1'b0, 1'b0);
    check("t5_data", 32'(data_out), 32'h07);
    check("t5_valid", 32'(data_valid), 32'h1);
    check("t5_overrun", 32'(overrun), 32'h0);

    // reset mid-word while a word is held
    tick(1'b1, 1'b1, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 1'b0, 1'b0);
    do_reset();
    check("t6_data", 32'(data_out), 32'h0);
    check("t6_valid", 32'(data_valid), 32'h0);
    check("t6_busy", 32'(busy), 32'h0);
    send_word(5'h19, 0, 1'b0, 1'b0, 1'b0);
    check("t6_new_data", 32'(data_out), 32'h19);

`ifdef SIPO_PARITY_EN
    // wrong parity: word is still delivered, error flag is set
    send_word(5'h16, 0, 1'b0, 1'b1, 1'b1);
    check("t7_data", 32'(data_out), 32'h16);
    check("t7_parity_err", 32'(parity_err), 32'h1);
`endif

    // randomized traffic against the reference model
    do_reset();
    for (int n = 0; n < 600; n++) begin
      logic en, st, b, rdy;
      en = logic'($urandom_range(0, 3) != 0);
      st = logic'($urandom_range(0, 7) == 0);
      b = logic'($urandom_range(0, 1));
      rdy = logic'($urandom_range(0, 2) == 0);
      tick(en, st, b, rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
